// File: rtl/encoder4_2_reg.sv
// Registered 4-to-2 priority encoder with a valid/ready output and one transfer per press.
// Define ENC_DEBOUNCE_EN to build the DEB state that requires DEB_CNT stable cycles before capture.
module encoder4_2_reg #(
    parameter int DEB_CNT = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [3:0] in,
    input  logic       out_ready,
    output logic [1:0] out_code,
    output logic       out_valid,
    output logic       err_multi,
    output logic [7:0] press_cnt,
    output logic       busy
);

    // Handshake: out_code/err_multi are held with out_valid until a rising edge
    // sees out_valid & out_ready; out_ready may already be high when out_valid rises.

    if (DEB_CNT < 1) begin : g_bad_deb_cnt
        $error("DEB_CNT must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        RELEASE = 2'd2
`ifdef ENC_DEBOUNCE_EN
        ,
        DEB     = 2'd3
`endif
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] in_meta;
    logic [3:0] in_sync;
    logic [3:0] cap_pat;
    logic       in_any;
    logic       capture;
    logic       transfer;

    function automatic logic [1:0] enc_code(input logic [3:0] p);
        if (p[3])      return 2'd3;
        else if (p[2]) return 2'd2;
        else if (p[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    // More than one bit set exactly when clearing the lowest set bit leaves something.
    function automatic logic enc_multi(input logic [3:0] p);
        return (p & (p - 4'd1)) != 4'd0;
    endfunction

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            in_meta <= 4'd0;
            in_sync <= 4'd0;
        end else begin
            in_meta <= in;
            in_sync <= in_meta;
        end
    end

    assign in_any = (in_sync != 4'd0);

`ifdef ENC_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CNT) + 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

    logic [3:0]       deb_pat;
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_same;
    logic             deb_done;

    assign deb_same = (in_sync == deb_pat);
    assign deb_done = deb_same && (deb_cnt == DEB_LAST);
    assign cap_pat  = deb_pat;

    // Any pattern change restarts the stability count from zero.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            deb_pat <= 4'd0;
            deb_cnt <= '0;
        end else if (state == IDLE) begin
            deb_pat <= in_sync;
            deb_cnt <= '0;
        end else if (state == DEB) begin
            if (!deb_same) begin
                deb_pat <= in_sync;
                deb_cnt <= '0;
            end else if (!deb_done) begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end
`else
    assign cap_pat = in_sync;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
`ifdef ENC_DEBOUNCE_EN
                if (in_any) state_next = DEB;
`else
                if (in_any) state_next = PRESENT;
`endif
            end
`ifdef ENC_DEBOUNCE_EN
            DEB: begin
                if (!in_any)       state_next = IDLE;
                else if (deb_done) state_next = PRESENT;
            end
`endif
            PRESENT: begin
                if (out_ready) state_next = RELEASE;
            end
            RELEASE: begin
                if (!in_any) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        capture  = 1'b0;
        transfer = 1'b0;
        busy     = (state != IDLE);
        case (state)
`ifdef ENC_DEBOUNCE_EN
            DEB:     capture  = in_any && deb_done;
`else
            IDLE:    capture  = in_any;
`endif
            PRESENT: transfer = out_ready;
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            out_code  <= 2'd0;
            err_multi <= 1'b0;
            out_valid <= 1'b0;
            press_cnt <= 8'd0;
        end else if (capture) begin
            out_code  <= enc_code(cap_pat);
            err_multi <= enc_multi(cap_pat);
            out_valid <= 1'b1;
        end else if (transfer) begin
            out_valid <= 1'b0;
            press_cnt <= press_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_encoder4_2_reg.sv
// Directed bench for encoder4_2_reg: table of encode vectors plus hand-written
// handshake, release, debounce, wrap and reset sequences.
module tb_encoder4_2_reg;

    localparam int DEB = 4;
`ifdef ENC_DEBOUNCE_EN
    localparam int LAT = DEB + 3;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        logic [3:0] pat;
        logic [1:0] code;
        logic       err;
    } vec_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [3:0] in;
    logic       out_ready;
    logic [1:0] out_code;
    logic       out_valid;
    logic       err_multi;
    logic [7:0] press_cnt;
    logic       busy;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_cnt;
    logic [2:0] exp_q[$];
    vec_t       vecs[9];

    encoder4_2_reg #(.DEB_CNT(DEB)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in        (in),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_valid (out_valid),
        .err_multi (err_multi),
        .press_cnt (press_cnt),
        .busy      (busy)
    );

    // clock / reset
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press_once(input logic [3:0] pat);
        int n;
        n = 0;
        in = pat;
        out_ready = 1'b1;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check("press_timeout", {31'd0, out_valid}, 32'd1);
        tick();
        exp_cnt = exp_cnt + 8'd1;
        in = 4'd0;
        repeat (4) tick();
    endtask

    initial begin
        int bad;
        int n_press;
        logic [2:0] exp_e;

        vecs[0] = '{4'b0001, 2'd0, 1'b0};
        vecs[1] = '{4'b0010, 2'd1, 1'b0};
        vecs[2] = '{4'b0100, 2'd2, 1'b0};
        vecs[3] = '{4'b1000, 2'd3, 1'b0};
        vecs[4] = '{4'b0011, 2'd1, 1'b1};
        vecs[5] = '{4'b0110, 2'd2, 1'b1};
        vecs[6] = '{4'b1111, 2'd3, 1'b1};
        vecs[7] = '{4'b1001, 2'd3, 1'b1};
        vecs[8] = '{4'b0101, 2'd2, 1'b1};

        // Test 1: reset, idle for 20 cycles
        sys_rst = 1'b1;
        in = 4'd0;
        out_ready = 1'b1;
        exp_cnt = 8'd0;
        @(negedge sys_clk);
        repeat (3) tick();
        sys_rst = 1'b0;
        bad = 0;
        repeat (20) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("idle_bad_cycles", bad, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_press_cnt", {24'd0, press_cnt}, 0);
        check("rst_out_code", {30'd0, out_code}, 0);
        check("rst_err_multi", {31'd0, err_multi}, 0);

        // Table: exact latency, encode, zero-wait accept, release to idle
        foreach (vecs[i]) begin
            exp_q.push_back({vecs[i].err, vecs[i].code});
            in = vecs[i].pat;
            out_ready = 1'b1;
            repeat (LAT - 1) tick();
            check("lat_early_valid", {31'd0, out_valid}, 0);
            tick();
            check("lat_valid", {31'd0, out_valid}, 1);
            exp_e = exp_q.pop_front();
            check("vec_code", {30'd0, out_code}, {30'd0, exp_e[1:0]});
            check("vec_err", {31'd0, err_multi}, {31'd0, exp_e[2]});
            tick();
            exp_cnt = exp_cnt + 8'd1;
            check("vec_drop_valid", {31'd0, out_valid}, 0);
            check("vec_press_cnt", {24'd0, press_cnt}, {24'd0, exp_cnt});
            in = 4'd0;
            repeat (4) tick();
            check("vec_idle_busy", {31'd0, busy}, 0);
        end

        // Test 2: held input gives one transfer only, until released
        in = 4'b0100;
        out_ready = 1'b1;
        repeat (LAT) tick();
        check("hold_code", {30'd0, out_code}, 2);
        tick();
        exp_cnt = exp_cnt + 8'd1;
        bad = 0;
        repeat (12) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        check("hold_no_second", bad, 0);
        check("hold_busy_release", {31'd0, busy}, 1);
        check("hold_press_cnt", {24'd0, press_cnt}, {24'd0, exp_cnt});
        in = 4'd0;
        repeat (4) tick();
        in = 4'b0100;
        repeat (LAT) tick();
        check("reapply_valid", {31'd0, out_valid}, 1);
        tick();
        exp_cnt = exp_cnt + 8'd1;
        in = 4'd0;
        repeat (4) tick();

        // Test 3: back-pressure holds code stable while inputs change
        in = 4'b1010;
        out_ready = 1'b0;
        repeat (LAT) tick();
        check("bp_valid", {31'd0, out_valid}, 1);
        check("bp_code", {30'd0, out_code}, 3);
        check("bp_err", {31'd0, err_multi}, 1);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 2) in = 4'b0001;
            tick();
            if (out_valid !== 1'b1 || out_code !== 2'd3 || err_multi !== 1'b1) bad++;
        end
        check("bp_stable", bad, 0);
        check("bp_cnt_hold", {24'd0, press_cnt}, {24'd0, exp_cnt});
        out_ready = 1'b1;
        tick();
        exp_cnt = exp_cnt + 8'd1;
        check("bp_drop", {31'd0, out_valid}, 0);
        check("bp_press_cnt", {24'd0, press_cnt}, {24'd0, exp_cnt});
        in = 4'd0;
        repeat (4) tick();

`ifdef ENC_DEBOUNCE_EN
        // Test 4: short glitch rejected, long hold accepted, pattern change restarts count
        in = 4'b0010;
        out_ready = 1'b0;
        repeat (3) tick();
        in = 4'd0;
        bad = 0;
        repeat (12) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        check("deb_glitch", bad, 0);
        in = 4'b0010;
        repeat (LAT - 1) tick();
        check("deb_early", {31'd0, out_valid}, 0);
        tick();
        check("deb_valid", {31'd0, out_valid}, 1);
        check("deb_code", {30'd0, out_code}, 1);
        out_ready = 1'b1;
        tick();
        exp_cnt = exp_cnt + 8'd1;
        in = 4'd0;
        repeat (4) tick();
        out_ready = 1'b0;
        in = 4'b0001;
        repeat (2) tick();
        in = 4'b0010;
        repeat (6) tick();
        check("deb_restart_early", {31'd0, out_valid}, 0);
        tick();
        check("deb_restart_valid", {31'd0, out_valid}, 1);
        check("deb_restart_code", {30'd0, out_code}, 1);
        out_ready = 1'b1;
        tick();
        exp_cnt = exp_cnt + 8'd1;
        in = 4'd0;
        repeat (4) tick();
`endif

        // Test 5: counter wraps, then reset while presenting
        n_press = 256 - int'(exp_cnt);
        for (int p = 0; p < n_press; p++) begin
            press_once(vecs[p % 9].pat);
            if (p == n_press - 2) check("wrap_255", {24'd0, press_cnt}, 255);
        end
        check("wrap_model", {24'd0, exp_cnt}, 0);
        check("wrap_zero", {24'd0, press_cnt}, {24'd0, exp_cnt});
        press_once(4'b1000);
        check("wrap_one", {24'd0, press_cnt}, {24'd0, exp_cnt});

        in = 4'b0100;
        out_ready = 1'b0;
        repeat (LAT) tick();
        check("pre_rst_valid", {31'd0, out_valid}, 1);
        sys_rst = 1'b1;
        #1;
        check("rst_mid_valid", {31'd0, out_valid}, 0);
        check("rst_mid_busy", {31'd0, busy}, 0);
        check("rst_mid_cnt", {24'd0, press_cnt}, 0);
        in = 4'd0;
        out_ready = 1'b1;
        @(negedge sys_clk);
        tick();
        sys_rst = 1'b0;
        bad = 0;
        repeat (8) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("rst_no_replay", bad, 0);
        check("rst_cnt_after", {24'd0, press_cnt}, 0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
